pwm_fade_ctrl: RTL and testbench

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_pkg.sv | 11 +
 rtl/pwm_period_tick.sv | 24 ++
 rtl/pwm_fade_ctrl.sv | 99 +++++++++
 tb/tb_pwm_fade_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: duty width/limits and fade FSM states.
package pwm_pkg;
    localparam int          DUTY_W   = 8;
    localparam logic [7:0]  DUTY_MAX = 8'd255;

    // Fade FSM state encoding
    typedef logic [1:0] fade_state_t;
    localparam fade_state_t IDLE      = 2'd0;
    localparam fade_state_t RAMP_UP   = 2'd1;
    localparam fade_state_t RAMP_DOWN = 2'd2;
endpackage

// File: rtl/pwm_period_tick.sv
// Free-running PWM period tick: one-cycle pulse every PERIOD = CLOCK_FREQUENCY/PWM_FREQUENCY cycles.
module pwm_period_tick #(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int PWM_FREQUENCY   = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam logic [31:0] PERIOD = 32'(CLOCK_FREQUENCY / PWM_FREQUENCY);

    logic [31:0] cnt;

    // The counter runs PERIOD..1; the edge where it would reach 0 is the tick and reloads it,
    // so the pulse repeats every PERIOD cycles exactly.
    assign tick = (cnt == 32'd1);

    // Down-counter with reload; never disturbed by request traffic
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       cnt <= PERIOD;
        else if (tick) cnt <= PERIOD;
        else           cnt <= cnt - 32'd1;
    end
endmodule

// File: rtl/pwm_fade_ctrl.sv
// PWM duty fade controller: accepts a target duty and ramps 1 LSB every STEP_PERIODS PWM
// periods, or jumps instantly. Optional macro FADE_DONE_EN adds a one-cycle 'done' pulse.
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100000000,
    parameter int PWM_FREQUENCY   = 1000,
    parameter int STEP_PERIODS    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DUTY_W-1:0] req_duty,
    input  logic              req_instant,
    output logic [DUTY_W-1:0] duty,
    output logic              busy
`ifdef FADE_DONE_EN
    ,
    output logic              done
`endif
);
    fade_state_t       state;
    logic [DUTY_W-1:0] target;
    logic [7:0]        step_cnt;
    logic [DUTY_W-1:0] duty_step;
    logic              tick;
    logic              accept;
    logic              step_due;

    pwm_period_tick #(
        .CLOCK_FREQUENCY(CLOCK_FREQUENCY),
        .PWM_FREQUENCY  (PWM_FREQUENCY)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Ready is held low while reset is asserted, then tracks IDLE
    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state == RAMP_UP) || (state == RAMP_DOWN);
    assign accept    = req_valid && req_ready;
    assign step_due  = busy && tick && (step_cnt == 8'(STEP_PERIODS - 1));

    // Next duty one LSB toward the target, saturating at the rails and at the target
    always_comb begin
        duty_step = duty;
        if (state == RAMP_UP && duty < target && duty != DUTY_MAX)
            duty_step = duty + 8'd1;
        else if (state == RAMP_DOWN && duty > target && duty != 8'd0)
            duty_step = duty - 8'd1;
    end

    // Fade FSM: request acceptance in IDLE, tick-paced stepping in the ramp states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            duty     <= '0;
            target   <= '0;
            step_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A tick landing on the accept edge is dropped: the step count starts at 0
                    if (accept) begin
                        target   <= req_duty;
                        step_cnt <= '0;
                        if (req_instant)          duty  <= req_duty;
                        else if (req_duty > duty) state <= RAMP_UP;
                        else if (req_duty < duty) state <= RAMP_DOWN;
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (step_due) begin
                        step_cnt <= '0;
                        duty     <= duty_step;
                        if (duty_step == target) state <= IDLE;
                    end else if (tick) begin
                        step_cnt <= step_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FADE_DONE_EN
    logic finish;
    assign finish = (accept && (req_instant || req_duty == duty)) ||
                    (step_due && duty_step == target);

    // One-cycle completion pulse; reset mid-ramp clears it so an aborted ramp never reports done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) done <= 1'b0;
        else     done <= finish;
    end
`endif
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl (PERIOD=10, STEP_PERIODS=2 -> one duty step per 20 cycles).
module tb_pwm_fade_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [7:0] req_duty = 8'd0;
    logic       req_instant = 1'b0;
    logic       req_ready;
    logic [7:0] duty;
    logic       busy;
`ifdef FADE_DONE_EN
    logic       done;
`endif

    always #5 clk = ~clk;

    pwm_fade_ctrl #(
        .CLOCK_FREQUENCY(1000),
        .PWM_FREQUENCY  (100),
        .STEP_PERIODS   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_duty   (req_duty),
        .req_instant(req_instant),
        .duty       (duty),
        .busy       (busy)
`ifdef FADE_DONE_EN
        ,
        .done       (done)
`endif
    );

    typedef struct { logic [7:0] val; int gap; } exp_t;
    exp_t q[$];

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: every duty change pops the next expected value; gap!=0 also checks step spacing
    initial begin
        logic [7:0] prev;
        int         last;
        exp_t       e;
        prev = 8'd0;
        last = 0;
        forever begin
            @(negedge clk);
            if (!$isunknown(duty) && duty !== prev) begin
                if (q.size() == 0) begin
                    check("unexpected_duty_change", 32'(duty), 32'(prev));
                end else begin
                    e = q.pop_front();
                    check("duty_step", 32'(duty), 32'(e.val));
                    if (e.gap != 0) check("step_gap", cyc - last, e.gap);
                end
                prev = duty;
                last = cyc;
            end
`ifdef FADE_DONE_EN
            if (done === 1'b1) done_cnt++;
`endif
        end
    end

    task automatic send(input logic [7:0] d, input logic inst);
        @(negedge clk);
        req_duty = d;
        req_instant = inst;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, 32'(n < 400), 32'd1);
    endtask

    initial begin
        int d0;
        int n;
        int bad;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_duty", 32'(duty), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'(req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(req_ready), 1);

        // Ramp up 0 -> 3
        q.push_back('{8'd1, 0});
        q.push_back('{8'd2, 20});
        q.push_back('{8'd3, 20});
        d0 = done_cnt;
        send(8'd3, 1'b0);
        @(negedge clk);
        check("ramp_up_busy", 32'(busy), 1);
        check("ramp_up_ready", 32'(req_ready), 0);
        wait_idle("ramp_up");
        check("ramp_up_final", 32'(duty), 3);
        check("ramp_up_ready_idle", 32'(req_ready), 1);
        repeat (2) @(negedge clk);
`ifdef FADE_DONE_EN
        check("ramp_up_done", done_cnt - d0, 1);
`endif

        // Ramp down 3 -> 0, no wrap
        q.push_back('{8'd2, 0});
        q.push_back('{8'd1, 20});
        q.push_back('{8'd0, 20});
        send(8'd0, 1'b0);
        @(negedge clk);
        check("ramp_down_busy", 32'(busy), 1);
        wait_idle("ramp_down");
        check("ramp_down_final", 32'(duty), 0);
        repeat (60) @(negedge clk);
        check("no_wrap_duty", 32'(duty), 0);
        check("no_wrap_busy", 32'(busy), 0);

        // Instant jump to 200
        q.push_back('{8'd200, 0});
        d0 = done_cnt;
        send(8'd200, 1'b1);
        @(negedge clk);
        check("instant_duty", 32'(duty), 200);
        check("instant_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
`ifdef FADE_DONE_EN
        check("instant_done", done_cnt - d0, 1);
`endif

        // Request held through a ramp 200 -> 202, then accepted on the first IDLE cycle
        q.push_back('{8'd201, 0});
        q.push_back('{8'd202, 20});
        q.push_back('{8'd201, 20});
        q.push_back('{8'd200, 20});
        @(negedge clk);
        req_duty = 8'd202;
        req_instant = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_duty = 8'd200;
        @(negedge clk);
        check("held_ramp_busy", 32'(busy), 1);
        bad = 0;
        n = 0;
        while (busy === 1'b1 && n < 400) begin
            if (req_ready !== 1'b0) bad++;
            @(negedge clk);
            n++;
        end
        check("held_timeout", 32'(n < 400), 1);
        check("held_ready_low_in_ramp", bad, 0);
        check("held_first_idle_ready", 32'(req_ready), 1);
        check("held_first_idle_duty", 32'(duty), 202);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("held_accepted", 32'(busy), 1);
        wait_idle("held_ramp_down");
        check("held_final", 32'(duty), 200);

        // Equal target: stays IDLE, duty unchanged
        d0 = done_cnt;
        send(8'd200, 1'b0);
        @(negedge clk);
        check("equal_busy", 32'(busy), 0);
        check("equal_duty", 32'(duty), 200);
        check("equal_ready", 32'(req_ready), 1);
        repeat (2) @(negedge clk);
`ifdef FADE_DONE_EN
        check("equal_done", done_cnt - d0, 1);
`endif

        // Reset mid-ramp at duty=2
        q.push_back('{8'd0, 0});
        send(8'd0, 1'b1);
        repeat (2) @(negedge clk);
        q.push_back('{8'd1, 0});
        q.push_back('{8'd2, 20});
        send(8'd3, 1'b0);
        n = 0;
        while (duty !== 8'd2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach2_timeout", 32'(n < 400), 1);
        d0 = done_cnt;
        q.push_back('{8'd0, 0});
        #2 rst = 1'b1;
        #1;
        check("async_rst_duty", 32'(duty), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_ready", 32'(req_ready), 0);
        repeat (3) @(negedge clk);
`ifdef FADE_DONE_EN
        check("abort_no_done", done_cnt - d0, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
